// File: rtl/date_pkg.sv
// Shared calendar constants and FSM state type for the date encoder/decoder pair.
// DATE_ENCODER_LEAP_EN enables the 29-day February when the leap flag is set.
package date_pkg;

    localparam logic [6:0] JAN_LEN = 7'd31;
    localparam logic [6:0] FEB_LEN = 7'd28;
    localparam logic [6:0] MAR_LEN = 7'd31;
    localparam logic [6:0] APR_LEN = 7'd30;

    localparam logic [1:0] MONTH_JAN = 2'd0;
    localparam logic [1:0] MONTH_FEB = 2'd1;
    localparam logic [1:0] MONTH_MAR = 2'd2;
    localparam logic [1:0] MONTH_APR = 2'd3;

`ifdef DATE_ENCODER_LEAP_EN
    localparam logic LEAP_EN = 1'b1;
`else
    localparam logic LEAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // With the leap feature compiled out the leap flag is masked to zero.
    function automatic logic [6:0] month_len(input logic [1:0] m, input logic leap);
        logic [6:0] len;
        case (m)
            MONTH_JAN: len = JAN_LEN;
            MONTH_FEB: len = FEB_LEN + {6'd0, leap & LEAP_EN};
            MONTH_MAR: len = MAR_LEN;
            default:   len = APR_LEN;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/date_encoder_bcd_day_check.sv
// Combinational BCD day decode and range check against the selected month length.
module bcd_day_check
    import date_pkg::*;
(
    input  logic [1:0] day_tens,
    input  logic [3:0] day_ones,
    input  logic [1:0] month,
    input  logic       leap,
    output logic [6:0] day,
    output logic       valid
);

    logic [6:0] len;

    always_comb begin
        day   = ({5'd0, day_tens} * 7'd10) + {3'd0, day_ones};
        len   = month_len(month, leap);
        valid = (day_ones <= 4'd9) && (day != 7'd0) && (day <= len);
    end

endmodule

// File: rtl/date_encoder.sv
// Month/BCD-day to day-of-year converter (Jan..Apr) with start/done handshake.
// Leap-year February is enabled by defining DATE_ENCODER_LEAP_EN.
module date_encoder
    import date_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] month,
    input  logic [1:0] dayTens,
    input  logic [3:0] dayOnes,
    input  logic       leapYear,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [6:0] date
);

    state_e     state_q, state_d;
    logic [1:0] month_q, month_d;
    logic [1:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       leap_q, leap_d;
    logic [6:0] acc_q, acc_d;
    logic [1:0] m_q, m_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [6:0] date_q, date_d;

    logic [6:0] chk_day;
    logic       chk_valid;

    bcd_day_check u_day_check (
        .day_tens (tens_q),
        .day_ones (ones_q),
        .month    (month_q),
        .leap     (leap_q),
        .day      (chk_day),
        .valid    (chk_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            month_q <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            leap_q  <= 1'b0;
            acc_q   <= '0;
            m_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            date_q  <= '0;
        end else begin
            state_q <= state_d;
            month_q <= month_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            leap_q  <= leap_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            date_q  <= date_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_CHECK;
            ST_CHECK: begin
                if (!chk_valid || (month_q == MONTH_JAN)) state_d = ST_DONE;
                else                                      state_d = ST_ACCUM;
            end
            ST_ACCUM: if ((m_q + 2'd1) == month_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are loaded from the next state so they appear registered in the DONE cycle.
    always_comb begin
        month_d = month_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        leap_d  = leap_q;
        acc_d   = acc_q;
        m_d     = m_q;
        date_d  = date_q;
        err_d   = err_q;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    month_d = month;
                    tens_d  = dayTens;
                    ones_d  = dayOnes;
                    leap_d  = leapYear;
                end
            end
            ST_CHECK: begin
                if (chk_valid) begin
                    acc_d = chk_day;
                    m_d   = 2'd0;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + month_len(m_q, leap_q);
                m_d   = m_q + 2'd1;
            end
            default: ;
        endcase

        if (state_d == ST_DONE) begin
            if ((state_q == ST_CHECK) && !chk_valid) begin
                date_d = 7'd0;
                err_d  = 1'b1;
            end else begin
                date_d = acc_d;
                err_d  = 1'b0;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign date = date_q;

endmodule

// File: tb/tb_date_encoder.sv
// Self-checking bench for date_encoder: directed calendar cases plus randomized requests.
module tb_date_encoder;

`ifdef DATE_ENCODER_LEAP_EN
    localparam bit LEAP_ON = 1'b1;
`else
    localparam bit LEAP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] month;
    logic [1:0] dayTens;
    logic [3:0] dayOnes;
    logic       leapYear;
    logic       busy;
    logic       done;
    logic       err;
    logic [6:0] date;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    date_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .month    (month),
        .dayTens  (dayTens),
        .dayOnes  (dayOnes),
        .leapYear (leapYear),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .date     (date)
    );

    // Reference: day-of-year from a month length table and a running sum.
    function automatic void model(input int m, input int t, input int o, input bit lp,
                                  output int d, output bit e);
        int lens[4];
        int day;
        lens = '{31, (LEAP_ON && lp) ? 29 : 28, 31, 30};
        day = t * 10 + o;
        if (o > 9 || day == 0 || day > lens[m]) begin
            d = 0;
            e = 1'b1;
        end else begin
            d = day;
            for (int k = 0; k < m; k++) d += lens[k];
            e = 1'b0;
        end
    endfunction

    // Issues one request and reports result, latency in edges after the start edge,
    // and whether busy/done behaved as a clean handshake.
    task automatic do_req(input logic [1:0] m, input logic [1:0] t, input logic [3:0] o,
                          input logic lp, output logic [6:0] d, output logic e,
                          output int lat, output bit hs_ok);
        d = '0; e = 1'b0; lat = -1; hs_ok = 1'b1;
        @(negedge clk);
        month = m; dayTens = t; dayOnes = o; leapYear = lp; start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        month    = 2'($urandom);
        dayTens  = 2'($urandom);
        dayOnes  = 4'($urandom);
        leapYear = 1'($urandom);
        if (busy !== 1'b1 || done !== 1'b0) hs_ok = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = i; d = date; e = err;
                if (busy !== 1'b1) hs_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) hs_ok = 1'b0;
        end
        if (lat > 0) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) hs_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; month = '0; dayTens = '0; dayOnes = '0; leapYear = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || date !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b err=%b date=%0d, want all 0", busy, done, err, date);
        end
    endtask

    typedef struct {
        logic [1:0] m;
        logic [1:0] t;
        logic [3:0] o;
        logic       lp;
        int         d;
        bit         e;
    } case_t;

    task automatic test_directed();
        case_t tbl[11];
        logic [6:0] d; logic e; int lat; bit hs;
        int exp_lat;
        tbl[0]  = '{2'd0, 2'd0, 4'd1,  1'b0, 1, 1'b0};
        tbl[1]  = '{2'd3, 2'd3, 4'd0,  1'b0, 120, 1'b0};
        tbl[2]  = '{2'd3, 2'd3, 4'd0,  1'b1, LEAP_ON ? 121 : 120, 1'b0};
        tbl[3]  = '{2'd2, 2'd0, 4'd1,  1'b1, LEAP_ON ? 61 : 60, 1'b0};
        tbl[4]  = '{2'd1, 2'd2, 4'd9,  1'b0, 0, 1'b1};
        tbl[5]  = '{2'd0, 2'd0, 4'd10, 1'b0, 0, 1'b1};
        tbl[6]  = '{2'd1, 2'd0, 4'd0,  1'b0, 0, 1'b1};
        tbl[7]  = '{2'd3, 2'd3, 4'd1,  1'b0, 0, 1'b1};
        tbl[8]  = '{2'd1, 2'd2, 4'd9,  1'b1, LEAP_ON ? 60 : 0, !LEAP_ON};
        tbl[9]  = '{2'd0, 2'd3, 4'd1,  1'b0, 31, 1'b0};
        tbl[10] = '{2'd1, 2'd2, 4'd8,  1'b0, 59, 1'b0};
        for (int i = 0; i < 11; i++) begin
            do_req(tbl[i].m, tbl[i].t, tbl[i].o, tbl[i].lp, d, e, lat, hs);
            exp_lat = tbl[i].e ? 1 : int'(tbl[i].m) + 1;
            tests_run++;
            if (int'(d) != tbl[i].d || e !== tbl[i].e) begin
                tests_failed++;
                $display("FAIL directed[%0d] result: date=%0d err=%b, want date=%0d err=%b",
                         i, d, e, tbl[i].d, tbl[i].e);
            end
            tests_run++;
            if (lat != exp_lat) begin
                tests_failed++;
                $display("FAIL directed[%0d] latency: %0d edges, want %0d", i, lat, exp_lat);
            end
            tests_run++;
            if (!hs) begin
                tests_failed++;
                $display("FAIL directed[%0d] handshake: busy/done sequence wrong", i);
            end
        end
    endtask

    task automatic test_hold();
        logic [6:0] d; logic e; int lat; bit hs;
        do_req(2'd2, 2'd1, 4'd5, 1'b0, d, e, lat, hs);
        repeat (6) begin
            @(negedge clk);
            month = 2'($urandom); dayTens = 2'($urandom); dayOnes = 4'($urandom);
        end
        #1;
        tests_run++;
        if (date !== 7'd74 || err !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold: date=%0d err=%b done=%b, want date=74 err=0 done=0", date, err, done);
        end
    endtask

    task automatic test_random();
        logic [6:0] d; logic e; int lat; bit hs;
        int m, t, o, ed, exp_lat; bit lp, ee;
        for (int i = 0; i < 40; i++) begin
            m  = $urandom_range(0, 3);
            t  = $urandom_range(0, 3);
            o  = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            lp = 1'($urandom);
            model(m, t, o, lp, ed, ee);
            exp_lat = ee ? 1 : m + 1;
            do_req(2'(m), 2'(t), 4'(o), lp, d, e, lat, hs);
            tests_run++;
            if (int'(d) != ed || e !== ee || lat != exp_lat || !hs) begin
                tests_failed++;
                $display("FAIL random[%0d] m=%0d t=%0d o=%0d lp=%b: date=%0d err=%b lat=%0d hs=%b, want date=%0d err=%b lat=%0d",
                         i, m, t, o, lp, d, e, lat, hs, ed, ee, exp_lat);
            end
        end
    endtask

    task automatic test_start_ignored();
        int n_done = 0;
        logic [6:0] first_date = '0;
        @(negedge clk);
        month = 2'd3; dayTens = 2'd1; dayOnes = 4'd2; leapYear = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        month = 2'd0; dayTens = 2'd0; dayOnes = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (n_done == 0) first_date = date;
                n_done++;
            end
        end
        tests_run++;
        if (n_done != 1 || first_date !== 7'd102) begin
            tests_failed++;
            $display("FAIL start_ignored: dones=%0d date=%0d, want dones=1 date=102", n_done, first_date);
        end
    endtask

    task automatic test_reset_abort();
        int n_done = 0;
        logic [6:0] d; logic e; int lat; bit hs;
        @(negedge clk);
        month = 2'd3; dayTens = 2'd2; dayOnes = 4'd0; leapYear = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || date !== 7'd0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_abort: busy=%b done=%b date=%0d err=%b, want all 0", busy, done, date, err);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        tests_run++;
        if (n_done != 0) begin
            tests_failed++;
            $display("FAIL reset_abort_no_done: dones=%0d, want 0", n_done);
        end
        do_req(2'd1, 2'd1, 4'd0, 1'b0, d, e, lat, hs);
        tests_run++;
        if (d !== 7'd41 || e !== 1'b0 || lat != 2 || !hs) begin
            tests_failed++;
            $display("FAIL after_reset_feb10: date=%0d err=%b lat=%0d hs=%b, want date=41 err=0 lat=2", d, e, lat, hs);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] d1, d2; logic e1, e2; int l1, l2; bit h1, h2;
        do_req(2'd3, 2'd0, 4'd9, 1'b0, d1, e1, l1, h1);
        do_req(2'd0, 2'd2, 4'd5, 1'b0, d2, e2, l2, h2);
        tests_run++;
        if (d1 !== 7'd99 || d2 !== 7'd25 || e1 !== 1'b0 || e2 !== 1'b0 || l1 != 4 || l2 != 1 || !h1 || !h2) begin
            tests_failed++;
            $display("FAIL back_to_back: dates=%0d,%0d errs=%b,%b lats=%0d,%0d, want 99,25 0,0 4,1",
                     d1, d2, e1, e2, l1, l2);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
